count_bcd_scan_display: RTL and testbench
=========================================

Name: count_bcd_scan_display

Overview:
- Downstream consumer of the 0–999 counter.
- Continuously samples the 10-bit count and converts it to 3-digit BCD using a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the three digits onto one active-low 7-segment bus with active-low digit enables.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 1000, clocks each digit stays lit before advancing; legal range ≥2.
- BLANK_CODE, 7'b1111111, segment pattern driven when a digit is blanked or in reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- count  input  10  binary value from upstream counter, nominally 0..999.
- bcd  output  12  latched conversion result {hundreds, tens, ones}, 4 bits each.
- bcd_valid  output  1  one-cycle pulse when bcd updates.
- overflow  output  1  high while latched result came from count > 999.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.

Behaviour:
- All outputs registered.
- While reset=0:
  - bcd=12'h000, bcd_valid=0, overflow=0, seg=BLANK_CODE, an=3'b111.
  - FSM goes to IDLE, prescaler=0, digit index=0.
- Converter FSM states: IDLE -> SHIFT -> DONE -> IDLE. Free-running, one conversion per 12 clocks.
  - IDLE (1 clk): capture count into shift register; clear BCD scratch.
  - SHIFT (10 clks): each clk, add 3 to every scratch nibble ≥5, then shift {scratch, bin} left by 1. An iteration counter (0..9) exits after the 10th shift.
  - DONE (1 clk): on its closing edge, load bcd and overflow, and assert bcd_valid for the following cycle only.
- Latency: bcd reflects count sampled at the IDLE edge 12 clocks before the bcd update edge.
  - First bcd_valid occurs 12 clocks after reset release.
  - bcd_valid is high exactly 1 cycle in every 12.
- Out-of-range input (captured value 1000..1023):
  - bcd saturates to 12'h999 and overflow=1.
  - overflow clears on the next conversion of an in-range value.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0->1->2->0.
- Scan outputs:
  - an = ~(3'b001 << index), so exactly one enable is low outside reset.
  - seg = decode of the selected bcd nibble, registered with an so both change on the same edge.
  - Decode values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles >9 give BLANK_CODE.
- Scan is independent of the converter.
  - A bcd update mid-digit changes seg on the next clock; an does not change.
- Reset asserted mid-conversion: abort the conversion, return to IDLE, discard partial result, apply reset values on that edge.
- count changing during SHIFT has no effect until the next IDLE capture.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit is blanked (seg=BLANK_CODE while an[2] low) when its nibble is 0.
  - Tens digit is blanked when hundreds and tens are both 0.
  - Ones digit is never blanked; value 0 shows a single "0".
  - With overflow=1, no digit is blanked.
- Undefined: all three digits are always decoded, e.g. 7 displays "007".

Test Plan:
- Hold reset=0 for 3 clks with count=10'd123 -> seg=1111111, an=111, bcd=000, bcd_valid=0. Release -> first bcd_valid 12 clks later with bcd=12'h123.
- count=999 steady -> bcd=12'h999, overflow=0. Then count=0 -> within 24 clks bcd=12'h000. Check bcd_valid period is exactly 12 clks.
- count=10'd1023 -> bcd=12'h999, overflow=1. Then count=10'd45 -> bcd=12'h045, overflow=0.
- SCAN_DIV=4, bcd=12'h507 -> an sequence 110,101,011 each for 4 clks. seg 1111000, 1000000, 0010010 respectively.
- LEADING_ZERO_BLANK_EN defined, count=7 -> tens and hundreds slots show 1111111, ones shows 1111000. Undefined -> the same slots show 1000000.
- Pull reset low 5 clks into SHIFT with count=512, release with count=300 -> no bcd_valid for the aborted run; next bcd=12'h300.

Source files
------------

// File: rtl/count_bcd_scan_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit multiplexed 7-segment scanner.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits unless the latched result overflowed.
`timescale 1ns/1ps
module count_bcd_scan_display #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter logic [6:0]  BLANK_CODE = 7'b1111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  count,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        overflow,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    localparam int unsigned  PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [9:0]  bin_q, bin_d;
    // Bit 12 is the thousands digit: it can only ever reach 1, so it doubles as the out-of-range flag.
    logic [12:0] scratch_q, scratch_d;
    logic [3:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic [11:0] adj;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = BLANK_CODE;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= BLANK_CODE;
            an_q      <= 3'b111;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        adj       = scratch_q[11:0];
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                bin_d     = count;
                scratch_d = '0;
                iter_d    = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                scratch_d = {adj, bin_q[9]};
                bin_d     = {bin_q[8:0], 1'b0};
                iter_d    = iter_q + 4'd1;
                if (iter_q == 4'd9)
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = scratch_q[12] ? 12'h999 : scratch_q[11:0];
                ovf_d   = scratch_q[12];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        case (idx_q)
            2'd0:    nib = bcd_q[3:0];
            2'd1:    nib = bcd_q[7:4];
            default: nib = bcd_q[11:8];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd2:    blank = (bcd_q[11:8] == 4'd0);
            2'd1:    blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && !ovf_q;
`else
        blank = 1'b0;
`endif
        seg_d = blank ? BLANK_CODE : seg_decode(nib);
        an_d  = ~(3'b001 << idx_q);
    end

    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign overflow  = ovf_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_count_bcd_scan_display.sv
// Directed self-checking bench for count_bcd_scan_display (SCAN_DIV=4 to keep scan checks short).
`timescale 1ns/1ps
module tb_count_bcd_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  count;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        overflow;
    logic [6:0]  seg;
    logic [2:0]  an;

    int total = 0;
    int bad   = 0;

    count_bcd_scan_display #(.SCAN_DIV(4), .BLANK_CODE(7'b1111111)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .overflow  (overflow),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic wait_valid(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bcd_valid) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: no bcd_valid within %0d clks", cycles);
        end
    endtask

    task automatic align_ones();
        logic [2:0] prev;
        bit         found;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == 3'b110 && prev != 3'b110) found = 1'b1;
            prev = an;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL scan_align: an never entered 110, last an=%b", an);
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b0;
        count = 10'd123;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL rst_seg: got %b want 1111111", seg); end
        total++; if (an !== 3'b111) begin bad++; $display("FAIL rst_an: got %b want 111", an); end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL rst_bcd: got %h want 000", bcd); end
        total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bcd_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        reset = 1'b1;
        wait_valid(cyc);
        total++; if (cyc != 12) begin bad++; $display("FAIL first_latency: got %0d want 12", cyc); end
        total++; if (bcd !== 12'h123) begin bad++; $display("FAIL first_bcd: got %h want 123", bcd); end
    endtask

    task automatic test_range();
        int  cyc;
        bit  seen0;
        count = 10'd999;
        wait_valid(cyc);
        wait_valid(cyc);
        total++; if (bcd !== 12'h999) begin bad++; $display("FAIL bcd_999: got %h want 999", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_999: got %b want 0", overflow); end
        wait_valid(cyc);
        total++; if (cyc != 12) begin bad++; $display("FAIL valid_period: got %0d want 12", cyc); end
        count = 10'd0;
        seen0 = 1'b0;
        for (int i = 0; i < 24 && !seen0; i++) begin
            @(negedge clk);
            if (bcd === 12'h000) seen0 = 1'b1;
        end
        total++; if (!seen0) begin bad++; $display("FAIL bcd_zero_24: got %h want 000 within 24 clks", bcd); end
    endtask

    task automatic test_overflow();
        int cyc;
        count = 10'd1023;
        wait_valid(cyc);
        wait_valid(cyc);
        total++; if (bcd !== 12'h999) begin bad++; $display("FAIL ovf_bcd: got %h want 999", bcd); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        count = 10'd45;
        wait_valid(cyc);
        wait_valid(cyc);
        total++; if (bcd !== 12'h045) begin bad++; $display("FAIL ovf_clear_bcd: got %h want 045", bcd); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_flag: got %b want 0", overflow); end
    endtask

    task automatic test_scan();
        int         cyc;
        logic [2:0] exp_an  [3];
        logic [6:0] exp_seg [3];
        exp_an[0] = 3'b110; exp_seg[0] = 7'b1111000;
        exp_an[1] = 3'b101; exp_seg[1] = 7'b1000000;
        exp_an[2] = 3'b011; exp_seg[2] = 7'b0010010;
        count = 10'd507;
        wait_valid(cyc);
        wait_valid(cyc);
        total++; if (bcd !== 12'h507) begin bad++; $display("FAIL scan_bcd: got %h want 507", bcd); end
        align_ones();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) begin
                total++; if (an !== exp_an[d]) begin bad++; $display("FAIL scan_an d%0d k%0d: got %b want %b", d, k, an, exp_an[d]); end
                total++; if (seg !== exp_seg[d]) begin bad++; $display("FAIL scan_seg d%0d k%0d: got %b want %b", d, k, seg, exp_seg[d]); end
                @(negedge clk);
            end
        end
        total++; if (an !== 3'b110) begin bad++; $display("FAIL scan_wrap: got %b want 110", an); end
    endtask

    task automatic test_leading_zero();
        int         cyc;
        logic [6:0] lead;
`ifdef LEADING_ZERO_BLANK_EN
        lead = 7'b1111111;
`else
        lead = 7'b1000000;
`endif
        count = 10'd7;
        wait_valid(cyc);
        wait_valid(cyc);
        align_ones();
        total++; if (seg !== 7'b1111000) begin bad++; $display("FAIL lz_ones: got %b want 1111000", seg); end
        repeat (4) @(negedge clk);
        total++; if (an !== 3'b101 || seg !== lead) begin bad++; $display("FAIL lz_tens: got an=%b seg=%b want an=101 seg=%b", an, seg, lead); end
        repeat (4) @(negedge clk);
        total++; if (an !== 3'b011 || seg !== lead) begin bad++; $display("FAIL lz_hund: got an=%b seg=%b want an=011 seg=%b", an, seg, lead); end
    endtask

    task automatic test_abort();
        int cyc;
        count = 10'd512;
        wait_valid(cyc);
        wait_valid(cyc);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        count = 10'd300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bcd_valid !== 1'b0) begin bad++; $display("FAIL abort_valid c%0d: got %b want 0", i, bcd_valid); end
        end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL abort_bcd_rst: got %h want 000", bcd); end
        total++; if (an !== 3'b111 || seg !== 7'b1111111) begin bad++; $display("FAIL abort_scan_rst: got an=%b seg=%b want 111/1111111", an, seg); end
        reset = 1'b1;
        wait_valid(cyc);
        total++; if (cyc != 12) begin bad++; $display("FAIL abort_latency: got %0d want 12", cyc); end
        total++; if (bcd !== 12'h300) begin bad++; $display("FAIL abort_bcd: got %h want 300", bcd); end
    endtask

    initial begin
        reset = 1'b0;
        count = '0;
        test_reset();
        test_range();
        test_overflow();
        test_scan();
        test_leading_zero();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
